// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter: master IDs,
// starve-counter width and the owner-pipe entry used to route acks.
package dmem_arbiter_pkg;

  localparam int unsigned CNT_W = 4;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  typedef struct packed {
    logic valid;
    logic id;
  } owner_t;

endpackage

// File: rtl/dmem_arbiter_starve_ctr.sv
// Counts consecutive m0 grants while m1 waits; flags when m1 must be served.
module arb_starve_ctr #(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);
  import dmem_arbiter_pkg::*;

  logic [CNT_W-1:0] cnt;

  assign at_limit = (cnt == CNT_W'(LIMIT));

  // Clear wins over increment; the count saturates at LIMIT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_limit) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master data-memory arbiter: m0 (CPU) priority with starvation guard for
// m1, one access per cycle, bus in N+1 and ack/read data in N+2.
module dmem_arbiter #(
  parameter int unsigned AW           = 16,
  parameter int unsigned DW           = 8,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_wr_en,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wr_data,
  output logic          m0_gnt,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rd_data,
  output logic          m0_stall,
  input  logic          m1_req,
  input  logic          m1_wr_en,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wr_data,
  output logic          m1_gnt,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rd_data,
  output logic          bus_valid,
  output logic          bus_wr_en,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wr_data,
  input  logic [DW-1:0] bus_rd_data
);
  import dmem_arbiter_pkg::*;

  logic         at_limit;
  logic         gnt0_c;
  logic         gnt1_c;
  owner_t [1:0] owner_q;
  logic [DW-1:0] m0_rd_q;
  logic [DW-1:0] m1_rd_q;

  // Grant decision; m1 wins when m0 is idle or m0 has used up its run.
  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (rst_n) begin
      if (m1_req && (!m0_req || at_limit)) begin
        gnt1_c = 1'b1;
      end else if (m0_req) begin
        gnt0_c = 1'b1;
      end
    end
  end

  assign m0_gnt   = gnt0_c;
  assign m1_gnt   = gnt1_c;
  assign m0_stall = m0_req & ~gnt0_c;

  arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (gnt0_c & m1_req),
    .clr      (gnt1_c | ~m1_req),
    .at_limit (at_limit)
  );

  // Capture the granted request onto the bus and record its owner.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus_valid   <= 1'b0;
      bus_wr_en   <= 1'b0;
      bus_addr    <= '0;
      bus_wr_data <= '0;
      owner_q     <= '0;
    end else begin
      bus_valid  <= gnt0_c | gnt1_c;
      owner_q[0] <= owner_t'{valid: gnt0_c | gnt1_c, id: (gnt1_c ? M1 : M0)};
      owner_q[1] <= owner_q[0];
      if (gnt1_c) begin
        bus_wr_en   <= m1_wr_en;
        bus_addr    <= m1_addr;
        bus_wr_data <= m1_wr_data;
      end else if (gnt0_c) begin
        bus_wr_en   <= m0_wr_en;
        bus_addr    <= m0_addr;
        bus_wr_data <= m0_wr_data;
      end else begin
        bus_wr_en   <= 1'b0;
      end
    end
  end

  assign m0_ack = owner_q[1].valid && (owner_q[1].id == M0);
  assign m1_ack = owner_q[1].valid && (owner_q[1].id == M1);

  // Read data arrives in the ack cycle, so it is passed straight through and
  // remembered for the cycles in between.
  assign m0_rd_data = m0_ack ? bus_rd_data : m0_rd_q;
  assign m1_rd_data = m1_ack ? bus_rd_data : m1_rd_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m0_rd_q <= '0;
      m1_rd_q <= '0;
    end else begin
      m0_rd_q <= m0_rd_data;
      m1_rd_q <= m1_rd_data;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic checked
// against a schedule-based reference model.
module tb_dmem_arbiter;
  localparam int unsigned AW   = 16;
  localparam int unsigned DW   = 8;
  localparam int unsigned LIM  = 4;
  localparam int          MAXC = 4096;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          m0_req, m0_wr_en, m0_gnt, m0_ack, m0_stall;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wr_data, m0_rd_data;
  logic          m1_req, m1_wr_en, m1_gnt, m1_ack;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wr_data, m1_rd_data;
  logic          bus_valid, bus_wr_en;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wr_data, bus_rd_data;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_wr_en(m0_wr_en), .m0_addr(m0_addr), .m0_wr_data(m0_wr_data),
    .m0_gnt(m0_gnt), .m0_ack(m0_ack), .m0_rd_data(m0_rd_data), .m0_stall(m0_stall),
    .m1_req(m1_req), .m1_wr_en(m1_wr_en), .m1_addr(m1_addr), .m1_wr_data(m1_wr_data),
    .m1_gnt(m1_gnt), .m1_ack(m1_ack), .m1_rd_data(m1_rd_data),
    .bus_valid(bus_valid), .bus_wr_en(bus_wr_en), .bus_addr(bus_addr),
    .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: grants scheduled as future bus/ack events by cycle index.
  int            cyc = 0;
  int            cnt = 0;
  bit            e_bv   [MAXC];
  bit            e_wr   [MAXC];
  logic [AW-1:0] e_addr [MAXC];
  logic [DW-1:0] e_wd   [MAXC];
  int            e_ack  [MAXC];
  logic [DW-1:0] held0 = '0;
  logic [DW-1:0] held1 = '0;
  bit            x_g0, x_g1, x_bv, x_wr, x_a0, x_a1;
  logic [AW-1:0] x_addr;
  logic [DW-1:0] x_wd, x_rd0, x_rd1;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic eval();
    int g;
    #1;
    g = -1;
    if (rst_n) begin
      if (m1_req && (!m0_req || cnt == int'(LIM))) g = 1;
      else if (m0_req) g = 0;
    end
    x_g0   = (g == 0);
    x_g1   = (g == 1);
    x_bv   = e_bv[cyc];
    x_wr   = e_wr[cyc];
    x_addr = e_addr[cyc];
    x_wd   = e_wd[cyc];
    x_a0   = (e_ack[cyc] == 0);
    x_a1   = (e_ack[cyc] == 1);
    x_rd0  = x_a0 ? bus_rd_data : held0;
    x_rd1  = x_a1 ? bus_rd_data : held1;
    held0  = x_rd0;
    held1  = x_rd1;
    if (!rst_n) begin
      cnt = 0;
      held0 = '0;
      held1 = '0;
      e_bv[cyc+1]   = 1'b0;
      e_wr[cyc+1]   = 1'b0;
      e_addr[cyc+1] = '0;
      e_wd[cyc+1]   = '0;
      e_ack[cyc+1]  = -1;
      e_ack[cyc+2]  = -1;
    end else begin
      e_bv[cyc+1]   = (g >= 0);
      e_wr[cyc+1]   = (g == 1) ? m1_wr_en : ((g == 0) ? m0_wr_en : 1'b0);
      e_addr[cyc+1] = (g == 1) ? m1_addr : m0_addr;
      e_wd[cyc+1]   = (g == 1) ? m1_wr_data : m0_wr_data;
      e_ack[cyc+2]  = g;
      if (!m1_req || g == 1) cnt = 0;
      else if (g == 0 && cnt < int'(LIM)) cnt++;
    end
    cyc++;
  endtask

  task automatic idle_inputs();
    m0_req = 1'b0; m0_wr_en = 1'b0; m0_addr = '0; m0_wr_data = '0;
    m1_req = 1'b0; m1_wr_en = 1'b0; m1_addr = '0; m1_wr_data = '0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      rst_n = 1'b0; idle_inputs(); m0_req = 1'b1; m1_req = 1'b1; bus_rd_data = 8'hFF;
      eval();
      n_cmp++;
      if ({m0_gnt, m1_gnt} !== 2'b00) begin
        n_fail++; $display("FAIL reset_gnt cyc=%0d got=%b exp=00", i, {m0_gnt, m1_gnt});
      end
    end
    n_cmp++;
    if ({bus_valid, bus_wr_en, bus_addr, bus_wr_data, m0_ack, m1_ack, m0_rd_data, m1_rd_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_vals got bv=%b we=%b a=%h wd=%h a0=%b a1=%b rd0=%h rd1=%h exp all 0",
               bus_valid, bus_wr_en, bus_addr, bus_wr_data, m0_ack, m1_ack, m0_rd_data, m1_rd_data);
    end
  endtask

  task automatic test_m0_read();
    next_cycle();
    rst_n = 1'b1; idle_inputs(); m0_req = 1'b1; m0_addr = 16'h1234; bus_rd_data = 8'h00;
    eval();
    n_cmp++;
    if ({m0_gnt, m1_gnt, m0_stall} !== 3'b100) begin
      n_fail++; $display("FAIL m0rd_gnt got=%b exp=100", {m0_gnt, m1_gnt, m0_stall});
    end
    next_cycle();
    idle_inputs();
    eval();
    n_cmp++;
    if ({bus_valid, bus_wr_en, bus_addr} !== {2'b10, 16'h1234}) begin
      n_fail++; $display("FAIL m0rd_bus got v=%b we=%b a=%h exp v=1 we=0 a=1234", bus_valid, bus_wr_en, bus_addr);
    end
    next_cycle();
    bus_rd_data = 8'hA5;
    eval();
    n_cmp++;
    if ({m0_ack, m1_ack, m0_rd_data} !== {2'b10, 8'hA5}) begin
      n_fail++; $display("FAIL m0rd_ack got a0=%b a1=%b rd=%h exp 1 0 a5", m0_ack, m1_ack, m0_rd_data);
    end
    next_cycle();
    bus_rd_data = 8'h3C;
    eval();
    n_cmp++;
    if ({m0_ack, m0_rd_data} !== {1'b0, 8'hA5}) begin
      n_fail++; $display("FAIL m0rd_hold got a0=%b rd=%h exp 0 a5", m0_ack, m0_rd_data);
    end
  endtask

  task automatic test_m1_write();
    next_cycle();
    idle_inputs(); m1_req = 1'b1; m1_wr_en = 1'b1; m1_addr = 16'h2000; m1_wr_data = 8'h5C;
    eval();
    n_cmp++;
    if ({m0_gnt, m1_gnt} !== 2'b01) begin
      n_fail++; $display("FAIL m1wr_gnt got=%b exp=01", {m0_gnt, m1_gnt});
    end
    next_cycle();
    idle_inputs();
    eval();
    n_cmp++;
    if ({bus_valid, bus_wr_en, bus_addr, bus_wr_data} !== {2'b11, 16'h2000, 8'h5C}) begin
      n_fail++; $display("FAIL m1wr_bus got v=%b we=%b a=%h wd=%h exp 1 1 2000 5c", bus_valid, bus_wr_en, bus_addr, bus_wr_data);
    end
    next_cycle();
    bus_rd_data = 8'h99;
    eval();
    n_cmp++;
    if ({m1_ack, m0_ack, m0_rd_data} !== {2'b10, 8'hA5}) begin
      n_fail++; $display("FAIL m1wr_ack got a1=%b a0=%b rd0=%h exp 1 0 a5", m1_ack, m0_ack, m0_rd_data);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      idle_inputs(); m0_req = (i < 4); m0_addr = AW'(i); bus_rd_data = DW'(8'h40 + i);
      eval();
      if (i < 4) begin
        n_cmp++;
        if (m0_gnt !== 1'b1) begin
          n_fail++; $display("FAIL b2b_gnt i=%0d got=%b exp=1", i, m0_gnt);
        end
      end
      if (i >= 1) begin
        n_cmp++;
        if (i <= 4 ? ({bus_valid, bus_addr} !== {1'b1, AW'(i - 1)}) : (bus_valid !== 1'b0)) begin
          n_fail++; $display("FAIL b2b_bus i=%0d got v=%b a=%h exp v=%0d a=%0d", i, bus_valid, bus_addr, i <= 4, i - 1);
        end
      end
      if (i >= 2) begin
        n_cmp++;
        if ({m0_ack, m0_rd_data} !== {1'b1, DW'(8'h40 + i)}) begin
          n_fail++; $display("FAIL b2b_ack i=%0d got a=%b rd=%h exp 1 %h", i, m0_ack, m0_rd_data, 8'h40 + i);
        end
      end
    end
  endtask

  task automatic test_starve();
    bit pat [15];
    for (int i = 0; i < 15; i++) pat[i] = (i % 5 == 4);
    for (int i = 0; i < 17; i++) begin
      next_cycle();
      idle_inputs();
      m0_req = (i < 15); m0_addr = 16'h0100;
      m1_req = (i < 15); m1_addr = 16'h0200;
      bus_rd_data = DW'($urandom);
      eval();
      if (i < 15) begin
        n_cmp++;
        if ({m0_gnt, m1_gnt, m0_stall} !== {~pat[i], pat[i], pat[i]}) begin
          n_fail++; $display("FAIL starve_gnt i=%0d got=%b exp=%b", i, {m0_gnt, m1_gnt, m0_stall}, {~pat[i], pat[i], pat[i]});
        end
      end
      if (i >= 2) begin
        n_cmp++;
        if ({m0_ack, m1_ack} !== {~pat[i-2], pat[i-2]}) begin
          n_fail++; $display("FAIL starve_ack i=%0d got=%b exp=%b", i, {m0_ack, m1_ack}, {~pat[i-2], pat[i-2]});
        end
      end
    end
  endtask

  task automatic test_drop();
    for (int i = 0; i < 11; i++) begin
      next_cycle();
      idle_inputs();
      m0_req = (i < 7); m0_addr = 16'h0300;
      m1_req = (i < 8) && (i != 2); m1_addr = 16'hBEEF;
      bus_rd_data = 8'h11;
      eval();
      if (i < 8) begin
        n_cmp++;
        if ({m0_gnt, m1_gnt} !== {i != 7, i == 7}) begin
          n_fail++; $display("FAIL drop_gnt i=%0d got=%b exp=%b", i, {m0_gnt, m1_gnt}, {i != 7, i == 7});
        end
      end
      n_cmp++;
      if (m1_ack !== (i == 9)) begin
        n_fail++; $display("FAIL drop_m1ack i=%0d got=%b exp=%b", i, m1_ack, i == 9);
      end
    end
  endtask

  task automatic test_reset_mid();
    next_cycle();
    idle_inputs(); m1_req = 1'b1; m1_wr_en = 1'b1; m1_addr = 16'h3344; m1_wr_data = 8'h77;
    eval();
    n_cmp++;
    if (m1_gnt !== 1'b1) begin
      n_fail++; $display("FAIL rmid_gnt got=%b exp=1", m1_gnt);
    end
    next_cycle();
    idle_inputs(); rst_n = 1'b0; m0_req = 1'b1;
    eval();
    n_cmp++;
    if ({m0_gnt, bus_valid, bus_wr_en, bus_wr_data} !== {3'b011, 8'h77}) begin
      n_fail++; $display("FAIL rmid_bus got g0=%b v=%b we=%b wd=%h exp 0 1 1 77", m0_gnt, bus_valid, bus_wr_en, bus_wr_data);
    end
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      idle_inputs(); rst_n = 1'b1; bus_rd_data = 8'hEE;
      eval();
      n_cmp++;
      if ({bus_valid, bus_wr_en, bus_addr, bus_wr_data, m0_ack, m1_ack, m0_rd_data, m1_rd_data} !== '0) begin
        n_fail++;
        $display("FAIL rmid_after i=%0d got bv=%b we=%b a=%h wd=%h a0=%b a1=%b rd0=%h rd1=%h exp all 0",
                 i, bus_valid, bus_wr_en, bus_addr, bus_wr_data, m0_ack, m1_ack, m0_rd_data, m1_rd_data);
      end
    end
  endtask

  task automatic test_random();
    bit p0 = 1'b0;
    bit p1 = 1'b0;
    for (int i = 0; i < 600; i++) begin
      next_cycle();
      rst_n = ($urandom_range(0, 99) != 0);
      if (!(p0 && $urandom_range(0, 9) != 0)) begin
        m0_req = ($urandom_range(0, 99) < 60); m0_wr_en = 1'($urandom);
        m0_addr = AW'($urandom); m0_wr_data = DW'($urandom);
      end
      if (!(p1 && $urandom_range(0, 9) != 0)) begin
        m1_req = ($urandom_range(0, 99) < 40); m1_wr_en = 1'($urandom);
        m1_addr = AW'($urandom); m1_wr_data = DW'($urandom);
      end
      bus_rd_data = DW'($urandom);
      eval();
      p0 = m0_req && !x_g0;
      p1 = m1_req && !x_g1;
      n_cmp++;
      if ({m0_gnt, m1_gnt, m0_stall, bus_valid, bus_wr_en, m0_ack, m1_ack, m0_rd_data, m1_rd_data} !==
          {x_g0, x_g1, m0_req & ~x_g0, x_bv, x_wr, x_a0, x_a1, x_rd0, x_rd1}) begin
        n_fail++;
        $display("FAIL rand_ctl i=%0d got g=%b%b st=%b v=%b we=%b ack=%b%b rd=%h/%h exp g=%b%b st=%b v=%b we=%b ack=%b%b rd=%h/%h",
                 i, m0_gnt, m1_gnt, m0_stall, bus_valid, bus_wr_en, m0_ack, m1_ack, m0_rd_data, m1_rd_data,
                 x_g0, x_g1, m0_req & ~x_g0, x_bv, x_wr, x_a0, x_a1, x_rd0, x_rd1);
      end
      if (x_bv) begin
        n_cmp++;
        if ({bus_addr, bus_wr_data} !== {x_addr, x_wd}) begin
          n_fail++; $display("FAIL rand_bus i=%0d got a=%h wd=%h exp a=%h wd=%h", i, bus_addr, bus_wr_data, x_addr, x_wd);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < MAXC; i++) begin
      e_bv[i] = 1'b0; e_wr[i] = 1'b0; e_addr[i] = '0; e_wd[i] = '0; e_ack[i] = -1;
    end
    rst_n = 1'b0;
    bus_rd_data = '0;
    idle_inputs();
    test_reset();
    test_m0_read();
    test_m1_write();
    test_back_to_back();
    test_starve();
    test_drop();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
